datapath_control_unit: RTL and testbench
========================================

Name: datapath_control_unit

Overview:
Moore-style hardwired control unit that sequences the DataPath through fetch (T0-T2) and per-instruction execute steps (T3-T7).
- Drives every DataPath control strobe.
- Decodes the latched IR contents.
- Honours the CON_out branch condition.
- Replaces hand-written testbench state sequencing and sits directly beside DataPath in the CPU top level.

Parameters:
ALU_ADD, 5'b00011, opcode driven to the ALU for address and PC-offset additions.
RESET_PC_HOLD, 1, number of cycles spent in the RESET state after clear deasserts.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
ir  input  32  IR register contents; opcode = ir[31:27], valid from T3 onward.
CON_out  input  1  branch condition from the CON FF logic.
PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout  output  1 each  bus-driver selects.
MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin, OutPortin  output  1 each  register load enables.
IncPC, Read, Write, Gra, Grb, Grc  output  1 each  PC increment, memory strobes, register-field selects.
Zhighout, ZHighIn, HIin, LOin, HIout, LOout, Yout  output  1 each  unused by this instruction subset; tied to 0.
opcode  output  5  ALU operation select.
run  output  1  high except in RESET and HALT.
state_dbg  output  4  current state encoding, for benches.

Behaviour:
- State register is updated on rising clock edges. clear=1 forces state RESET at the next edge, regardless of current state, including mid-instruction or HALT.
- All outputs are combinational decodes of the registered state and ir. In RESET and HALT every strobe is 0, opcode=0 and run=0.
- States and encodings: RESET=0, T0=7, T1=8, T2=9, T3=10, T4=11, T5=12, T6=13, T7=14, HALT=15.
- RESET goes to T0 after RESET_PC_HOLD cycles with clear low.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute steps by ir[31:27]. Any state not listed for an opcode returns to T0.
  - add 00011, sub 00100, and 00101, or 00110:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, opcode=ir[31:27], ZLowIn.
    - T5: Zlowout, Gra, Rin.
  - addi 01100:
    - T3: Grb, Rout, Yin.
    - T4: Cout, opcode=ALU_ADD, ZLowIn.
    - T5: Zlowout, Gra, Rin.
  - ld 00000:
    - T3: Grb, BAout, Yin.
    - T4: Cout, opcode=ALU_ADD, ZLowIn.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - st 00001:
    - T3-T5 as ld.
    - T6: Gra, Rout, MDRin with Read=0.
    - T7: Write.
  - in 10110, T3: InPortout, Gra, Rin.
  - out 10111, T3: Gra, Rout, OutPortin.
  - br 10010:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, opcode=ALU_ADD, ZLowIn.
    - T6: if CON_out=1, Zlowout and PCin; otherwise no strobes.
  - jr 10011, T3: Gra, Rout, PCin.
  - nop 11010 and every undefined opcode: T3 with no strobes, then T0.
  - halt 11011: T3 goes to HALT. HALT persists until clear.
- CON_out is sampled only in T6 of br. A change in any other state has no effect.
- Mutual exclusion: at most one bus driver (PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout) is high in any state. Read and Write are never both high.
- Instruction latency, fetch included:
  - ALU/addi: 6 cycles.
  - ld/st: 8 cycles.
  - br: 7 cycles.
  - in/out/jr/nop: 4 cycles.

Test Plan:
- Reset: clear=1 for 2 edges, then 0 → state_dbg=0, all strobes 0, run=0. After 1 cycle state_dbg=7 with PCout=MARin=IncPC=ZLowIn=1.
- ALU: ir=32'h18918000 (add R1,R2,R3) → T4 opcode=5'b00011 with Grc=Rout=ZLowIn=1; T5 Zlowout=Gra=Rin=1; next state T0. Total 6 cycles.
- Load: ir=32'h00900054 (ld R1,0x54(R2)) → T3 BAout=Grb=Yin=1; T6 Read=MDRin=1; T7 MDRout=Gra=Rin=1. Return to T0 after 8 cycles. Check Read and Write never both high.
- Out: ir=32'hBB000000 (out R6) → T3 Gra=Rout=OutPortin=1, then T0.
- Branch: br with CON_out=1 → T6 Zlowout=PCin=1. Repeat with CON_out=0 → T6 all strobes 0. Both cases then go to T0.
- Halt and reset mid-instruction: ir=32'hD8000000 → HALT, state_dbg=15, run=0, held for 20 cycles. Then assert clear during T5 of a ld → next state RESET, all strobes 0.

Source files
------------

// File: rtl/datapath_control_unit.sv
// Hardwired Moore control unit: sequences DataPath through fetch (T0-T2) and
// per-opcode execute steps (T3-T7), decoding strobes from state and IR.
module datapath_control_unit #(
   parameter logic [4:0] ALU_ADD       = 5'b00011,
   parameter int         RESET_PC_HOLD = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        CON_out,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        BAout,
   output logic        Rout,
   output logic        Cout,
   output logic        InPortout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        ZLowIn,
   output logic        Rin,
   output logic        CONin,
   output logic        OutPortin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Zhighout,
   output logic        ZHighIn,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Yout,
   output logic [4:0]  opcode,
   output logic        run,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd7,
      S_T1    = 4'd8,
      S_T2    = 4'd9,
      S_T3    = 4'd10,
      S_T4    = 4'd11,
      S_T5    = 4'd12,
      S_T6    = 4'd13,
      S_T7    = 4'd14,
      S_HALT  = 4'd15
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00001;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Last hold-counter value spent in RESET; a hold of 0 behaves like 1.
   localparam logic [7:0] HOLD_LAST = (RESET_PC_HOLD > 1) ? 8'(RESET_PC_HOLD - 1) : 8'd0;

   state_t      state, next_state;
   logic [7:0]  hold_cnt;
   logic [4:0]  op;
   logic        is_alu, is_addi, is_ld, is_st, is_mem, is_br;
   logic        unused_ir;

   assign op        = ir[31:27];
   assign unused_ir = ^ir[26:0];
   assign is_alu    = (op == 5'b00011) || (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
   assign is_addi   = (op == OP_ADDI);
   assign is_ld     = (op == OP_LD);
   assign is_st     = (op == OP_ST);
   assign is_mem    = is_ld || is_st;
   assign is_br     = (op == OP_BR);

   assign run       = (state != S_RESET) && (state != S_HALT);
   assign state_dbg = state;
   assign Zhighout  = 1'b0;
   assign ZHighIn   = 1'b0;
   assign HIin      = 1'b0;
   assign LOin      = 1'b0;
   assign HIout     = 1'b0;
   assign LOout     = 1'b0;
   assign Yout      = 1'b0;

   // clear wins over everything, including HALT and mid-instruction states.
   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= S_RESET;
         hold_cnt <= 8'd0;
      end else begin
         state    <= next_state;
         hold_cnt <= (state == S_RESET) ? hold_cnt + 8'd1 : 8'd0;
      end
   end

   always_comb begin
      next_state = state;
      {PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout} = '0;
      {MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin, OutPortin} = '0;
      {IncPC, Read, Write, Gra, Grb, Grc} = '0;
      opcode = 5'b00000;
      case (state)
         S_RESET: if (hold_cnt >= HOLD_LAST) next_state = S_T0;
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            next_state = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            next_state = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            next_state = S_T3;
         end
         S_T3: begin
            next_state = S_T0;
            if (is_alu || is_addi) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; next_state = S_T4;
            end else if (is_mem) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; next_state = S_T4;
            end else if (is_br) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; next_state = S_T4;
            end else if (op == OP_IN) begin
               InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op == OP_OUT) begin
               Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
            end else if (op == OP_JR) begin
               Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end else if (op == OP_HALT) begin
               next_state = S_HALT;
            end
         end
         S_T4: begin
            next_state = S_T0;
            if (is_alu) begin
               Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = op; next_state = S_T5;
            end else if (is_addi || is_mem) begin
               Cout = 1'b1; ZLowIn = 1'b1; opcode = ALU_ADD; next_state = S_T5;
            end else if (is_br) begin
               PCout = 1'b1; Yin = 1'b1; next_state = S_T5;
            end
         end
         S_T5: begin
            next_state = S_T0;
            if (is_alu || is_addi) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_mem) begin
               Zlowout = 1'b1; MARin = 1'b1; next_state = S_T6;
            end else if (is_br) begin
               Cout = 1'b1; ZLowIn = 1'b1; opcode = ALU_ADD; next_state = S_T6;
            end
         end
         S_T6: begin
            next_state = S_T0;
            if (is_ld) begin
               Read = 1'b1; MDRin = 1'b1; next_state = S_T7;
            end else if (is_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; next_state = S_T7;
            end else if (is_br && CON_out) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T7: begin
            next_state = S_T0;
            if (is_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         S_HALT:  next_state = S_HALT;
         default: next_state = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Table-driven bench for datapath_control_unit: per-cycle strobe vectors for
// each instruction class, plus hand sequences for reset, HALT and mid-instruction clear.
module tb_datapath_control_unit;

   localparam logic [21:0] PCOUT     = 22'd1 << 21;
   localparam logic [21:0] ZLOWOUT   = 22'd1 << 20;
   localparam logic [21:0] MDROUT    = 22'd1 << 19;
   localparam logic [21:0] BAOUT     = 22'd1 << 18;
   localparam logic [21:0] ROUT      = 22'd1 << 17;
   localparam logic [21:0] COUT      = 22'd1 << 16;
   localparam logic [21:0] INPORTOUT = 22'd1 << 15;
   localparam logic [21:0] MARIN     = 22'd1 << 14;
   localparam logic [21:0] PCIN      = 22'd1 << 13;
   localparam logic [21:0] MDRIN     = 22'd1 << 12;
   localparam logic [21:0] IRIN      = 22'd1 << 11;
   localparam logic [21:0] YIN       = 22'd1 << 10;
   localparam logic [21:0] ZLOWIN    = 22'd1 << 9;
   localparam logic [21:0] RIN       = 22'd1 << 8;
   localparam logic [21:0] CONIN     = 22'd1 << 7;
   localparam logic [21:0] OUTPORTIN = 22'd1 << 6;
   localparam logic [21:0] INCPC     = 22'd1 << 5;
   localparam logic [21:0] READ      = 22'd1 << 4;
   localparam logic [21:0] WRITE     = 22'd1 << 3;
   localparam logic [21:0] GRA       = 22'd1 << 2;
   localparam logic [21:0] GRB       = 22'd1 << 1;
   localparam logic [21:0] GRC       = 22'd1 << 0;

   typedef struct {
      logic [31:0] ir;
      logic        con;
      logic [3:0]  st;
      logic [21:0] strb;
      logic [4:0]  op;
      logic        run;
   } vec_t;

   logic        clock, clear, conOut;
   logic [31:0] ir;
   logic PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout;
   logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin, OutPortin;
   logic IncPC, Read, Write, Gra, Grb, Grc;
   logic Zhighout, ZHighIn, HIin, LOin, HIout, LOout, Yout;
   logic [4:0] opcode;
   logic       run;
   logic [3:0] stateDbg;
   logic [21:0] strobes;
   logic [6:0]  busDrivers;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   datapath_control_unit dut (
      .clock(clock), .clear(clear), .ir(ir), .CON_out(conOut),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Rout(Rout),
      .Cout(Cout), .InPortout(InPortout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .Rin(Rin), .CONin(CONin),
      .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
      .Grb(Grb), .Grc(Grc), .Zhighout(Zhighout), .ZHighIn(ZHighIn), .HIin(HIin),
      .LOin(LOin), .HIout(HIout), .LOout(LOout), .Yout(Yout), .opcode(opcode),
      .run(run), .state_dbg(stateDbg)
   );

   assign strobes = {PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout,
                     MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin, OutPortin,
                     IncPC, Read, Write, Gra, Grb, Grc};
   assign busDrivers = {PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout};

   // Free-running 10-unit clock; inputs change and outputs are sampled on the falling edge.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic addRow(input logic [31:0] i, input logic c, input logic [3:0] s,
                         input logic [21:0] b, input logic [4:0] o, input logic r);
      vec_t v;
      v.ir = i; v.con = c; v.st = s; v.strb = b; v.op = o; v.run = r;
      vecs.push_back(v);
   endtask

   task automatic addFetch(input logic [31:0] i);
      addRow(i, 1'b0, 4'd7, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 1'b1);
      addRow(i, 1'b0, 4'd8, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b1);
      addRow(i, 1'b0, 4'd9, MDROUT | IRIN, 5'd0, 1'b1);
   endtask

   task automatic stepClock();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic applyStimulus(input logic clr, input logic [31:0] i, input logic c);
      clear = clr; ir = i; conOut = c;
      #1;
   endtask

   // Compares the full output picture of the current state plus the exclusion rules.
   task automatic checkOutput(input int tag, input logic [3:0] expSt, input logic [21:0] expStrb,
                              input logic [4:0] expOp, input logic expRun);
      checks++;
      if (stateDbg !== expSt || strobes !== expStrb || opcode !== expOp || run !== expRun ||
          {Zhighout, ZHighIn, HIin, LOin, HIout, LOout, Yout} !== 7'd0) begin
         errors++;
         $display("[TB] FAIL step %0d: state=%0d exp %0d strobes=%h exp %h opcode=%b exp %b run=%b exp %b",
                  tag, stateDbg, expSt, strobes, expStrb, opcode, expOp, run, expRun);
      end
      checks++;
      if ($countones(busDrivers) > 1 || (Read && Write)) begin
         errors++;
         $display("[TB] FAIL exclusion step %0d: drivers=%b read=%b write=%b exp one-hot-or-zero, not both",
                  tag, busDrivers, Read, Write);
      end
   endtask

   initial begin
      logic [31:0] irAdd, irSub, irAddi, irLd, irSt, irOut, irIn, irJr, irNop, irUnd, irBr, irHalt;
      irAdd = 32'h18918000; irSub = 32'h20000000; irAddi = 32'h60000000;
      irLd  = 32'h00900054; irSt  = 32'h08900054; irOut  = 32'hBB000000;
      irIn  = 32'hB0000000; irJr  = 32'h98000000; irNop  = 32'hD0000000;
      irUnd = 32'h78000000; irBr  = 32'h90000000; irHalt = 32'hD8000000;

      addFetch(irAdd);
      addRow(irAdd, 0, 4'd10, GRB | ROUT | YIN, 5'd0, 1);
      addRow(irAdd, 0, 4'd11, GRC | ROUT | ZLOWIN, 5'b00011, 1);
      addRow(irAdd, 0, 4'd12, ZLOWOUT | GRA | RIN, 5'd0, 1);
      addFetch(irSub);
      addRow(irSub, 0, 4'd10, GRB | ROUT | YIN, 5'd0, 1);
      addRow(irSub, 0, 4'd11, GRC | ROUT | ZLOWIN, 5'b00100, 1);
      addRow(irSub, 0, 4'd12, ZLOWOUT | GRA | RIN, 5'd0, 1);
      addFetch(irAddi);
      addRow(irAddi, 0, 4'd10, GRB | ROUT | YIN, 5'd0, 1);
      addRow(irAddi, 0, 4'd11, COUT | ZLOWIN, 5'b00011, 1);
      addRow(irAddi, 0, 4'd12, ZLOWOUT | GRA | RIN, 5'd0, 1);
      addFetch(irLd);
      addRow(irLd, 0, 4'd10, GRB | BAOUT | YIN, 5'd0, 1);
      addRow(irLd, 0, 4'd11, COUT | ZLOWIN, 5'b00011, 1);
      addRow(irLd, 0, 4'd12, ZLOWOUT | MARIN, 5'd0, 1);
      addRow(irLd, 0, 4'd13, READ | MDRIN, 5'd0, 1);
      addRow(irLd, 0, 4'd14, MDROUT | GRA | RIN, 5'd0, 1);
      addFetch(irSt);
      addRow(irSt, 0, 4'd10, GRB | BAOUT | YIN, 5'd0, 1);
      addRow(irSt, 0, 4'd11, COUT | ZLOWIN, 5'b00011, 1);
      addRow(irSt, 0, 4'd12, ZLOWOUT | MARIN, 5'd0, 1);
      addRow(irSt, 0, 4'd13, GRA | ROUT | MDRIN, 5'd0, 1);
      addRow(irSt, 0, 4'd14, WRITE, 5'd0, 1);
      addFetch(irOut);
      addRow(irOut, 0, 4'd10, GRA | ROUT | OUTPORTIN, 5'd0, 1);
      addFetch(irIn);
      addRow(irIn, 0, 4'd10, INPORTOUT | GRA | RIN, 5'd0, 1);
      addFetch(irJr);
      addRow(irJr, 0, 4'd10, GRA | ROUT | PCIN, 5'd0, 1);
      addFetch(irNop);
      addRow(irNop, 0, 4'd10, 22'd0, 5'd0, 1);
      addFetch(irUnd);
      addRow(irUnd, 0, 4'd10, 22'd0, 5'd0, 1);
      // Branch taken, with CON_out toggling outside T6 to show it is ignored there.
      addFetch(irBr);
      addRow(irBr, 0, 4'd10, GRA | ROUT | CONIN, 5'd0, 1);
      addRow(irBr, 0, 4'd11, PCOUT | YIN, 5'd0, 1);
      addRow(irBr, 0, 4'd12, COUT | ZLOWIN, 5'b00011, 1);
      addRow(irBr, 1, 4'd13, ZLOWOUT | PCIN, 5'd0, 1);
      addFetch(irBr);
      addRow(irBr, 1, 4'd10, GRA | ROUT | CONIN, 5'd0, 1);
      addRow(irBr, 1, 4'd11, PCOUT | YIN, 5'd0, 1);
      addRow(irBr, 1, 4'd12, COUT | ZLOWIN, 5'b00011, 1);
      addRow(irBr, 0, 4'd13, 22'd0, 5'd0, 1);
      addFetch(irHalt);
      addRow(irHalt, 0, 4'd10, 22'd0, 5'd0, 1);
      addRow(irHalt, 0, 4'd15, 22'd0, 5'd0, 0);

      // Reset: clear held for two edges, then one cycle in RESET before T0.
      clear = 1'b1; ir = 32'd0; conOut = 1'b0;
      stepClock();
      stepClock();
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput(1000, 4'd0, 22'd0, 5'd0, 1'b0);
      stepClock();

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(1'b0, vecs[k].ir, vecs[k].con);
         checkOutput(k, vecs[k].st, vecs[k].strb, vecs[k].op, vecs[k].run);
         stepClock();
      end

      // HALT persists for 20 cycles even as IR and CON_out change underneath it.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, (k < 10) ? irHalt : irAdd, k[0]);
         checkOutput(2000 + k, 4'd15, 22'd0, 5'd0, 1'b0);
         stepClock();
      end

      // Leave HALT through clear, then abort a ld in T5.
      applyStimulus(1'b1, irLd, 1'b0);
      stepClock();
      applyStimulus(1'b0, irLd, 1'b0);
      checkOutput(3000, 4'd0, 22'd0, 5'd0, 1'b0);
      stepClock();
      checkOutput(3001, 4'd7, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 1'b1);
      for (int k = 0; k < 5; k++) stepClock();
      checkOutput(3002, 4'd12, ZLOWOUT | MARIN, 5'd0, 1'b1);
      applyStimulus(1'b1, irLd, 1'b0);
      stepClock();
      checkOutput(3003, 4'd0, 22'd0, 5'd0, 1'b0);
      stepClock();
      checkOutput(3004, 4'd0, 22'd0, 5'd0, 1'b0);
      applyStimulus(1'b0, irLd, 1'b0);
      stepClock();
      checkOutput(3005, 4'd7, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
